// File: rtl/vga_timing_lock_ctrl_if.sv
// Host/receiver-side signal bundle for the VGA timing lock supervisor.
// No valid/ready pairs here: iCfgWe and iErrClr are single-cycle strobes sampled on the clock edge.
interface vga_timing_lock_ctrl_if #(
  parameter int H_OFF_W = 6,
  parameter int V_OFF_W = 6,
  parameter int CNT_W   = 16
);
  logic               iHsync;
  logic               iVsync;
  logic               iEnable;
  logic               iCfgWe;
  logic [H_OFF_W-1:0] iHOffset;
  logic [V_OFF_W-1:0] iVOffset;
  logic               iErrClr;
  logic [H_OFF_W-1:0] oHsyncOffset;
  logic [V_OFF_W-1:0] oVsyncOffset;
  logic               oRecvRst;
  logic               oLocked;
  logic               oErr;
  logic [CNT_W-1:0]   oLinePeriod;
  logic [CNT_W-1:0]   oFrameLines;
  logic [2:0]         oState;
  logic [2:0]         oGoodCnt;

  modport master (
    output iHsync, iVsync, iEnable, iCfgWe, iHOffset, iVOffset, iErrClr,
    input  oHsyncOffset, oVsyncOffset, oRecvRst, oLocked, oErr,
    input  oLinePeriod, oFrameLines, oState, oGoodCnt
  );

  modport slave (
    input  iHsync, iVsync, iEnable, iCfgWe, iHOffset, iVOffset, iErrClr,
    output oHsyncOffset, oVsyncOffset, oRecvRst, oLocked, oErr,
    output oLinePeriod, oFrameLines, oState, oGoodCnt
  );
endinterface

// File: rtl/vga_timing_lock_ctrl.sv
// Measures hsync/vsync timing, declares lock after consecutive good frames, holds the
// receiver in reset while unlocked and applies host sync offsets on frame boundaries.
module vga_timing_lock_ctrl #(
  parameter int H_TOTAL     = 32,
  parameter int V_TOTAL     = 24,
  parameter int H_TOL       = 2,
  parameter int LOCK_FRAMES = 4,
  parameter int CNT_W       = 16
) (
  input logic                   iClk,
  input logic                   iRstN,
  vga_timing_lock_ctrl_if.slave bus
);
  localparam int H_OFF_W = $clog2(H_TOTAL) + 1;
  localparam int V_OFF_W = $clog2(V_TOTAL) + 1;
  localparam int GW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] H_NOM = CNT_W'(2 * H_TOTAL);
  localparam logic [CNT_W-1:0] H_TMO = CNT_W'(8 * H_TOTAL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_V  = 3'd1,
    S_MEASURE = 3'd2,
    S_LOCKED  = 3'd3,
    S_LOST    = 3'd4
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_goodCnt;
  logic               r_locked, r_recvRst, r_err;
  logic [7:0]         r_hSh, r_vSh;
  logic [CNT_W-1:0]   r_hCnt, r_lineCnt, r_linePeriod, r_frameLines;
  logic               r_frameBad, r_exempt;
  logic [H_OFF_W-1:0] r_hShadow, r_hOff;
  logic [V_OFF_W-1:0] r_vShadow, r_vOff;

  logic               w_hEdge, w_vEdge, w_restart, w_timeout, w_hBad, w_good;
  logic [CNT_W-1:0]   w_hDev;

  // A qualified edge needs four low samples followed by four high samples.
  assign w_hEdge   = (r_hSh == 8'h0F);
  assign w_vEdge   = (r_vSh == 8'h0F);
  assign w_restart = bus.iEnable && (r_state == S_WAIT_V) && w_vEdge;
  assign w_timeout = (r_hCnt > H_TMO);
  assign w_hDev    = (r_hCnt > H_NOM) ? (r_hCnt - H_NOM) : (H_NOM - r_hCnt);
  assign w_hBad    = (w_hDev > CNT_W'(H_TOL));
  assign w_good    = !r_frameBad && (r_lineCnt == CNT_W'(V_TOTAL));

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_hSh        <= '0;
      r_vSh        <= '0;
      r_hCnt       <= '0;
      r_lineCnt    <= '0;
      r_linePeriod <= '0;
      r_frameLines <= '0;
      r_frameBad   <= 1'b0;
      r_exempt     <= 1'b0;
      r_hShadow    <= '0;
      r_vShadow    <= '0;
      r_hOff       <= '0;
      r_vOff       <= '0;
    end else begin
      r_hSh <= {r_hSh[6:0], bus.iHsync};
      r_vSh <= {r_vSh[6:0], bus.iVsync};

      if (w_hEdge || w_restart)      r_hCnt <= CNT_W'(1);
      else if (r_hCnt != '1)         r_hCnt <= r_hCnt + CNT_W'(1);

      if (w_vEdge)                   r_lineCnt <= '0;
      else if (w_hEdge && r_lineCnt != '1) r_lineCnt <= r_lineCnt + CNT_W'(1);

      if (w_hEdge) r_linePeriod <= r_hCnt;
      if (w_vEdge) r_frameLines <= r_lineCnt + CNT_W'(w_hEdge);

      // The first line after a restart is measured from vsync, not hsync, so it is not judged.
      if (w_restart)    r_exempt <= 1'b1;
      else if (w_hEdge) r_exempt <= 1'b0;

      if (w_vEdge)
        r_frameBad <= 1'b0;
      else if ((w_hEdge && !r_exempt && w_hBad) || w_timeout)
        r_frameBad <= 1'b1;

      if (bus.iCfgWe) begin
        r_hShadow <= bus.iHOffset;
        r_vShadow <= bus.iVOffset;
      end
      if (w_vEdge || r_state == S_IDLE) begin
        r_hOff <= bus.iCfgWe ? bus.iHOffset : r_hShadow;
        r_vOff <= bus.iCfgWe ? bus.iVOffset : r_vShadow;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_state   <= S_IDLE;
      r_goodCnt <= '0;
      r_locked  <= 1'b0;
      r_recvRst <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_LOST)  r_err <= 1'b1;
      else if (bus.iErrClr)   r_err <= 1'b0;

      if (!bus.iEnable) begin
        r_state   <= S_IDLE;
        r_goodCnt <= '0;
        r_locked  <= 1'b0;
        r_recvRst <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_WAIT_V;
            r_goodCnt <= '0;
            r_locked  <= 1'b0;
            r_recvRst <= 1'b1;
          end
          S_WAIT_V: begin
            if (w_vEdge) begin
              r_state   <= S_MEASURE;
              r_goodCnt <= '0;
            end
          end
          S_MEASURE: begin
            if (w_timeout) begin
              r_state   <= S_WAIT_V;
              r_goodCnt <= '0;
            end else if (w_vEdge) begin
              if (!w_good) begin
                r_goodCnt <= '0;
              end else begin
                r_goodCnt <= r_goodCnt + GW'(1);
                if (r_goodCnt == GW'(LOCK_FRAMES - 1)) begin
                  r_state   <= S_LOCKED;
                  r_locked  <= 1'b1;
                  r_recvRst <= 1'b0;
                end
              end
            end
          end
          S_LOCKED: begin
            if (w_timeout || (w_vEdge && !w_good)) begin
              r_state   <= S_LOST;
              r_locked  <= 1'b0;
              r_recvRst <= 1'b1;
            end
          end
          S_LOST: begin
            r_state   <= S_WAIT_V;
            r_goodCnt <= '0;
          end
          default: begin
            r_state   <= S_IDLE;
            r_goodCnt <= '0;
            r_locked  <= 1'b0;
            r_recvRst <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.oHsyncOffset = r_hOff;
  assign bus.oVsyncOffset = r_vOff;
  assign bus.oRecvRst     = r_recvRst;
  assign bus.oLocked      = r_locked;
  assign bus.oErr         = r_err;
  assign bus.oLinePeriod  = r_linePeriod;
  assign bus.oFrameLines  = r_frameLines;
  assign bus.oState       = r_state;
  assign bus.oGoodCnt     = r_goodCnt;
endmodule

// File: tb/tb_vga_timing_lock_ctrl.sv
// Directed bench for vga_timing_lock_ctrl: a frame-by-frame vector table plus hand-written
// sequences for timeout, offset configuration, enable and reset corner cases.
module tb_vga_timing_lock_ctrl;
  localparam int ST_IDLE = 0, ST_WAIT_V = 1, ST_MEAS = 2, ST_LOCKED = 3, ST_LOST = 4;

  logic iClk = 1'b0;
  logic iRstN = 1'b0;

  vga_timing_lock_ctrl_if bus ();

  vga_timing_lock_ctrl dut (
    .iClk (iClk),
    .iRstN(iRstN),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    bit rst;
    int lines;
    int odd;
    int st;
    int good;
    bit lk;
    bit rr;
    bit err;
    int flines;
    int period;
  } vec_t;

  vec_t vecs[17];
  logic [5:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_line(input int len, input bit vs);
    for (int c = 0; c < len; c++) begin
      bus.iHsync = (c < 8);
      bus.iVsync = vs && (c >= 20) && (c < 28);
      tick();
    end
  endtask

  task automatic do_frame(input int lines, input int odd);
    for (int l = 0; l < lines; l++) do_line((l == 5) ? odd : 64, l == 0);
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    bus.iEnable = 1'b0;
    tick();
    tick();
    iRstN = 1'b1;
    bus.iEnable = 1'b1;
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, bus.oState, ST_IDLE);
    chk({tag, "_good"}, bus.oGoodCnt, 0);
    chk({tag, "_locked"}, bus.oLocked, 0);
    chk({tag, "_recvrst"}, bus.oRecvRst, 1);
    chk({tag, "_err"}, bus.oErr, 0);
    chk({tag, "_hoff"}, bus.oHsyncOffset, 0);
    chk({tag, "_voff"}, bus.oVsyncOffset, 0);
    chk({tag, "_period"}, bus.oLinePeriod, 0);
    chk({tag, "_flines"}, bus.oFrameLines, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // rst lines odd  state     good lk rr err flines period
    vecs[0]  = '{1, 24, 64, ST_MEAS,   0, 0, 1, 0, 1,  64};
    vecs[1]  = '{0, 24, 64, ST_MEAS,   1, 0, 1, 0, 24, 64};
    vecs[2]  = '{0, 24, 64, ST_MEAS,   2, 0, 1, 0, 24, 64};
    vecs[3]  = '{0, 24, 64, ST_MEAS,   3, 0, 1, 0, 24, 64};
    vecs[4]  = '{0, 24, 64, ST_LOCKED, 4, 1, 0, 0, 24, 64};
    vecs[5]  = '{0, 24, 66, ST_LOCKED, 4, 1, 0, 0, 24, 64};
    vecs[6]  = '{0, 24, 67, ST_LOCKED, 4, 1, 0, 0, 24, 64};
    vecs[7]  = '{0, 24, 64, ST_WAIT_V, 0, 0, 1, 1, 24, 64};
    vecs[8]  = '{0, 24, 64, ST_MEAS,   0, 0, 1, 1, 24, 64};
    vecs[9]  = '{0, 24, 64, ST_MEAS,   1, 0, 1, 1, 24, 64};
    vecs[10] = '{0, 24, 64, ST_MEAS,   2, 0, 1, 1, 24, 64};
    vecs[11] = '{0, 24, 64, ST_MEAS,   3, 0, 1, 1, 24, 64};
    vecs[12] = '{0, 24, 64, ST_LOCKED, 4, 1, 0, 1, 24, 64};
    vecs[13] = '{1, 23, 64, ST_MEAS,   0, 0, 1, 0, 1,  64};
    vecs[14] = '{0, 23, 64, ST_MEAS,   0, 0, 1, 0, 23, 64};
    vecs[15] = '{0, 23, 64, ST_MEAS,   0, 0, 1, 0, 23, 64};
    vecs[16] = '{0, 23, 64, ST_MEAS,   0, 0, 1, 0, 23, 64};

    bus.iHsync = 1'b0;
    bus.iVsync = 1'b0;
    bus.iEnable = 1'b0;
    bus.iCfgWe = 1'b0;
    bus.iHOffset = '0;
    bus.iVOffset = '0;
    bus.iErrClr = 1'b0;
    iRstN = 1'b0;
    tick();
    tick();
    chk_reset("init");
    iRstN = 1'b1;
    tick();
    chk("init_idle_hold", bus.oState, ST_IDLE);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst) do_reset();
      do_frame(vecs[i].lines, vecs[i].odd);
      chk($sformatf("v%0d_state", i), bus.oState, vecs[i].st);
      chk($sformatf("v%0d_good", i), bus.oGoodCnt, vecs[i].good);
      chk($sformatf("v%0d_locked", i), bus.oLocked, vecs[i].lk);
      chk($sformatf("v%0d_recvrst", i), bus.oRecvRst, vecs[i].rr);
      chk($sformatf("v%0d_err", i), bus.oErr, vecs[i].err);
      chk($sformatf("v%0d_flines", i), bus.oFrameLines, vecs[i].flines);
      chk($sformatf("v%0d_period", i), bus.oLinePeriod, vecs[i].period);
    end

    // hsync stops while locked; iErrClr lands in the LOST cycle
    do_reset();
    repeat (5) do_frame(24, 64);
    chk("tmo_pre_locked", bus.oState, ST_LOCKED);
    bus.iHsync = 1'b1;
    n = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (k == 8) bus.iHsync = 1'b0;
      if (bus.oState == 3'(ST_LOST)) begin
        n = k;
        break;
      end
    end
    chk("tmo_latency", n, 262);
    chk("tmo_locked", bus.oLocked, 0);
    chk("tmo_recvrst", bus.oRecvRst, 1);
    bus.iErrClr = 1'b1;
    tick();
    bus.iErrClr = 1'b0;
    chk("lost_errclr_err", bus.oErr, 1);
    chk("lost_next_state", bus.oState, ST_WAIT_V);

    // offsets: held mid-frame, applied at vEdge, same-cycle write at vEdge, immediate in IDLE
    exp_q.push_back(6'd3);
    exp_q.push_back(6'd7);
    exp_q.push_back(6'd9);
    bus.iCfgWe = 1'b1;
    bus.iHOffset = 6'd3;
    bus.iVOffset = 6'd5;
    tick();
    bus.iCfgWe = 1'b0;
    repeat (3) tick();
    chk("cfg_hold_hoff", bus.oHsyncOffset, 0);
    chk("cfg_hold_voff", bus.oVsyncOffset, 0);
    bus.iVsync = 1'b1;
    repeat (8) tick();
    bus.iVsync = 1'b0;
    repeat (8) tick();
    chk("cfg_vedge_hoff", bus.oHsyncOffset, exp_q.pop_front());
    chk("cfg_vedge_voff", bus.oVsyncOffset, 5);
    bus.iVsync = 1'b1;
    repeat (4) tick();
    bus.iCfgWe = 1'b1;
    bus.iHOffset = 6'd7;
    tick();
    bus.iCfgWe = 1'b0;
    chk("cfg_coinc_hoff", bus.oHsyncOffset, exp_q.pop_front());
    repeat (3) tick();
    bus.iVsync = 1'b0;
    repeat (8) tick();
    chk("cfg_coinc_keep", bus.oHsyncOffset, 7);
    bus.iEnable = 1'b0;
    tick();
    chk("cfg_idle_state", bus.oState, ST_IDLE);
    bus.iCfgWe = 1'b1;
    bus.iHOffset = 6'd9;
    bus.iVOffset = 6'd11;
    tick();
    bus.iCfgWe = 1'b0;
    chk("cfg_idle_hoff", bus.oHsyncOffset, exp_q.pop_front());
    chk("cfg_idle_voff", bus.oVsyncOffset, 11);

    // enable drop while locked keeps the sticky error; then clear; then reset mid-frame
    bus.iEnable = 1'b1;
    tick();
    repeat (5) do_frame(24, 64);
    chk("ctl_locked", bus.oState, ST_LOCKED);
    chk("ctl_locked_out", bus.oLocked, 1);
    chk("ctl_recvrst", bus.oRecvRst, 0);
    chk("ctl_err_sticky", bus.oErr, 1);
    chk("ctl_hoff", bus.oHsyncOffset, 9);
    bus.iEnable = 1'b0;
    tick();
    chk("ctl_dis_state", bus.oState, ST_IDLE);
    chk("ctl_dis_err", bus.oErr, 1);
    chk("ctl_dis_locked", bus.oLocked, 0);
    chk("ctl_dis_recvrst", bus.oRecvRst, 1);
    bus.iErrClr = 1'b1;
    tick();
    bus.iErrClr = 1'b0;
    chk("ctl_errclr", bus.oErr, 0);
    bus.iEnable = 1'b1;
    tick();
    do_line(64, 1'b1);
    do_line(64, 1'b0);
    chk("ctl_midframe_state", bus.oState, ST_MEAS);
    iRstN = 1'b0;
    tick();
    chk_reset("midrst");
    iRstN = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
